// File: rtl/intc_timer.sv
// intc_timer: mtime/mtimecmp timer, software and external interrupt source.
// Define INTC_PRESCALER_EN to tick mtime once every PRESCALE_DIV clocks.
module intc_timer #(
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  bus_addr,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic        ext_irq,
   input  logic        int_ack,
   output logic        interrupt,
   output logic [31:0] int_cause
);

   localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

   localparam logic [4:0] A_MSIP   = 5'h00;
   localparam logic [4:0] A_IE     = 5'h04;
   localparam logic [4:0] A_CMP_LO = 5'h08;
   localparam logic [4:0] A_CMP_HI = 5'h0C;
   localparam logic [4:0] A_TIM_LO = 5'h10;
   localparam logic [4:0] A_TIM_HI = 5'h14;
   localparam logic [4:0] A_EXTCTL = 5'h18;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic        msie;
   logic        mtie;
   logic        meie;
   logic        ext_mode;
   logic        ext_sticky;
   logic        sync1;
   logic        sync2;
   logic        sync3;
   logic        tick;
   logic        ext_rise;
   logic        ext_clr;
   logic        ext_pend;
   logic        tmr_pend;
   logic        irq_nxt;
   logic [31:0] cause_nxt;
   logic [31:0] rd_val;

   logic wr_msip;
   logic wr_ie;
   logic wr_cmp_lo;
   logic wr_cmp_hi;
   logic wr_tim_lo;
   logic wr_tim_hi;
   logic wr_extctl;

   assign wr_msip   = bus_we && (bus_addr == A_MSIP);
   assign wr_ie     = bus_we && (bus_addr == A_IE);
   assign wr_cmp_lo = bus_we && (bus_addr == A_CMP_LO);
   assign wr_cmp_hi = bus_we && (bus_addr == A_CMP_HI);
   assign wr_tim_lo = bus_we && (bus_addr == A_TIM_LO);
   assign wr_tim_hi = bus_we && (bus_addr == A_TIM_HI);
   assign wr_extctl = bus_we && (bus_addr == A_EXTCTL);

`ifdef INTC_PRESCALER_EN
   localparam logic [15:0] PRE_LAST = 16'(PRESCALE_DIV - 1);

   logic [15:0] pre_cnt;

   // Prescaler: counts 0..DIV-1, restarts on any mtime write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt <= '0;
      end else if (wr_tim_lo || wr_tim_hi) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);
`else
   // Undivided build ticks every clock; PRESCALE_DIV is always nonzero.
   assign tick = (PRESCALE_DIV != 0);
`endif

   // mtime: a word write beats the increment and leaves the other word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime <= '0;
      end else if (wr_tim_lo) begin
         mtime[31:0] <= bus_wdata;
      end else if (wr_tim_hi) begin
         mtime[63:32] <= bus_wdata;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // Software-visible control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtimecmp <= '1;
         msip     <= 1'b0;
         msie     <= 1'b0;
         mtie     <= 1'b0;
         meie     <= 1'b0;
         ext_mode <= 1'b0;
      end else begin
         if (wr_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
         if (wr_cmp_hi) mtimecmp[63:32] <= bus_wdata;
         if (wr_msip)   msip            <= bus_wdata[0];
         if (wr_ie) begin
            msie <= bus_wdata[3];
            mtie <= bus_wdata[7];
            meie <= bus_wdata[11];
         end
         if (wr_extctl) ext_mode <= bus_wdata[0];
      end
   end

   // Two-flop synchroniser plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= ext_irq;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign ext_rise = sync2 && !sync3;
   assign ext_clr  = (int_ack && (int_cause == CAUSE_MEI))
                  || (wr_extctl && bus_wdata[1]);
   assign ext_pend = ext_mode ? (ext_sticky || ext_rise) : sync2;
   assign tmr_pend = (mtime >= mtimecmp);

   // Sticky edge request; a new edge outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext_sticky <= 1'b0;
      end else if (ext_mode && ext_rise) begin
         ext_sticky <= 1'b1;
      end else if (ext_clr) begin
         ext_sticky <= 1'b0;
      end
   end

   // Fixed priority select: external, then software, then timer.
   always_comb begin
      cause_nxt = '0;
      if (meie && ext_pend) begin
         cause_nxt = CAUSE_MEI;
      end else if (msie && msip) begin
         cause_nxt = CAUSE_MSI;
      end else if (mtie && tmr_pend) begin
         cause_nxt = CAUSE_MTI;
      end
   end

   assign irq_nxt = (cause_nxt != '0);

   // Registered request level and cause toward the exception unit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         interrupt <= 1'b0;
         int_cause <= '0;
      end else begin
         interrupt <= irq_nxt;
         int_cause <= cause_nxt;
      end
   end

   // Read mux over the current register state.
   always_comb begin
      rd_val = '0;
      case (bus_addr)
         A_MSIP:   rd_val = {31'b0, msip};
         A_IE:     rd_val = {20'b0, meie, 3'b0, mtie, 3'b0, msie, 3'b0};
         A_CMP_LO: rd_val = mtimecmp[31:0];
         A_CMP_HI: rd_val = mtimecmp[63:32];
         A_TIM_LO: rd_val = mtime[31:0];
         A_TIM_HI: rd_val = mtime[63:32];
         A_EXTCTL: rd_val = {30'b0, ext_pend, ext_mode};
         default:  rd_val = '0;
      endcase
   end

   // Read data is captured on the strobe and held until the next read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_rdata <= '0;
      end else if (bus_re) begin
         bus_rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_intc_timer.sv
// tb_intc_timer: directed and random checks of intc_timer against
// a transaction-level reference model.
module tb_intc_timer;

   localparam int unsigned DIV = 4;
   localparam logic [31:0] C_MEI = 32'h8000_000B;
   localparam logic [31:0] C_MSI = 32'h8000_0003;
   localparam logic [31:0] C_MTI = 32'h8000_0007;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  bus_addr = '0;
   logic        bus_we = 1'b0;
   logic        bus_re = 1'b0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        ext_irq = 1'b0;
   logic        int_ack = 1'b0;
   logic        interrupt;
   logic [31:0] int_cause;

   int n_tests = 0;
   int n_fail = 0;

   intc_timer #(.PRESCALE_DIV(DIV)) dut (
      .clk(clk),
      .rst(rst),
      .bus_addr(bus_addr),
      .bus_we(bus_we),
      .bus_re(bus_re),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .ext_irq(ext_irq),
      .int_ack(int_ack),
      .interrupt(interrupt),
      .int_cause(int_cause)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   logic        m_msip;
   logic [31:0] m_ie;
   logic        m_mode;
   logic        m_epend;
   logic        m_int;
   logic [31:0] m_cause;
   logic [31:0] m_rdata;
   logic        m_pin_q[$];
   logic        m_sprev;
   int unsigned m_pre;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_time = '0;
      m_cmp = '1;
      m_msip = 1'b0;
      m_ie = '0;
      m_mode = 1'b0;
      m_epend = 1'b0;
      m_int = 1'b0;
      m_cause = '0;
      m_rdata = '0;
      m_pin_q = '{1'b0, 1'b0};
      m_sprev = 1'b0;
      m_pre = 0;
   endtask

   function automatic logic [31:0] m_read(logic [4:0] a, logic ep);
      case (a)
         5'h00: return {31'b0, m_msip};
         5'h04: return m_ie;
         5'h08: return m_cmp[31:0];
         5'h0C: return m_cmp[63:32];
         5'h10: return m_time[31:0];
         5'h14: return m_time[63:32];
         5'h18: return {30'b0, ep, m_mode};
         default: return 32'h0;
      endcase
   endfunction

   // One clock of architectural behaviour, from the inputs applied.
   task automatic model_edge();
      logic s, rise, ep, tp, set, clr, tk, mw;
      logic [31:0] c;
      s = m_pin_q[0];
      rise = s && !m_sprev;
      ep = m_mode ? (m_epend || rise) : s;
      tp = (m_time >= m_cmp);
      c = 32'h0;
      if (m_ie[11] && ep) c = C_MEI;
      else if (m_ie[3] && m_msip) c = C_MSI;
      else if (m_ie[7] && tp) c = C_MTI;
      if (bus_re) m_rdata = m_read(bus_addr, ep);
      set = m_mode && rise;
      clr = (int_ack && m_cause == C_MEI)
         || (bus_we && bus_addr == 5'h18 && bus_wdata[1]);
      mw = bus_we && (bus_addr == 5'h10 || bus_addr == 5'h14);
`ifdef INTC_PRESCALER_EN
      tk = (m_pre == DIV - 1);
      if (mw || tk) m_pre = 0;
      else m_pre++;
`else
      tk = 1'b1;
`endif
      if (!mw && tk) m_time = m_time + 64'd1;
      if (bus_we) begin
         case (bus_addr)
            5'h00: m_msip = bus_wdata[0];
            5'h04: m_ie = bus_wdata & 32'h888;
            5'h08: m_cmp[31:0] = bus_wdata;
            5'h0C: m_cmp[63:32] = bus_wdata;
            5'h10: m_time[31:0] = bus_wdata;
            5'h14: m_time[63:32] = bus_wdata;
            5'h18: m_mode = bus_wdata[0];
            default: ;
         endcase
      end
      if (set) m_epend = 1'b1;
      else if (clr) m_epend = 1'b0;
      m_int = (c != 32'h0);
      m_cause = c;
      m_sprev = s;
      void'(m_pin_q.pop_front());
      m_pin_q.push_back(ext_irq);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
      check("interrupt", interrupt, m_int);
      check("int_cause", int_cause, m_cause);
      check("bus_rdata", bus_rdata, m_rdata);
   endtask

   task automatic wr(logic [4:0] a, logic [31:0] d);
      bus_addr = a;
      bus_wdata = d;
      bus_we = 1'b1;
      step();
      bus_we = 1'b0;
   endtask

   task automatic rd(logic [4:0] a, output logic [31:0] d);
      bus_addr = a;
      bus_re = 1'b1;
      step();
      bus_re = 1'b0;
      d = bus_rdata;
   endtask

   task automatic do_reset();
      ext_irq = 1'b0;
      bus_we = 1'b0;
      bus_re = 1'b0;
      int_ack = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_interrupt", interrupt, 0);
      check("rst_cause", int_cause, 0);
      check("rst_rdata", bus_rdata, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic pulse_ext();
      ext_irq = 1'b1;
      step();
      ext_irq = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic found;
      logic [4:0] a;
      int unsigned la;

      // reset values
      do_reset();
      rd(5'h10, d);
      check("reset_mtime_lo", d, 32'h0);
      rd(5'h14, d);
      check("reset_mtime_hi", d, 32'h0);
      rd(5'h08, d);
      check("reset_cmp_lo", d, 32'hFFFF_FFFF);
      rd(5'h0C, d);
      check("reset_cmp_hi", d, 32'hFFFF_FFFF);

      // timer compare
      wr(5'h0C, 32'h0);
      wr(5'h14, 32'h0);
      wr(5'h10, 32'h0);
      wr(5'h08, 32'd10);
      wr(5'h04, 32'h80);
      found = 1'b0;
      for (int k = 0; k < 80 && !found; k++) begin
         step();
         if (interrupt) found = 1'b1;
      end
      check("timer_rise", found, 1);
      check("timer_cause", int_cause, C_MTI);
      repeat (5) step();
      check("timer_level", interrupt, 1);
      wr(5'h08, 32'hFFFF_FFFF);
      step();
      check("timer_clear", interrupt, 0);

      // edge external
      wr(5'h18, 32'h1);
      wr(5'h04, 32'h800);
      pulse_ext();
      step();
      check("edge_not_yet", interrupt, 0);
      step();
      check("edge_3clk", interrupt, 1);
      check("edge_cause", int_cause, C_MEI);
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      check("ack_hold", interrupt, 1);
      step();
      check("ack_drop", interrupt, 0);

      // priority chain
      wr(5'h0C, 32'h0);
      wr(5'h08, 32'h0);
      wr(5'h00, 32'h1);
      wr(5'h04, 32'h888);
      pulse_ext();
      step();
      step();
      check("prio_mei", int_cause, C_MEI);
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      step();
      check("prio_msi", int_cause, C_MSI);
      wr(5'h00, 32'h0);
      step();
      check("prio_mti", int_cause, C_MTI);
      wr(5'h08, 32'hFFFF_FFFF);
      wr(5'h0C, 32'hFFFF_FFFF);
      wr(5'h04, 32'h0);

      // mtime write against a tick
      wr(5'h14, 32'h5);
      wr(5'h10, 32'hFFFF_FFFF);
      rd(5'h10, d);
      check("coll_lo", d, 32'hFFFF_FFFF);
`ifdef INTC_PRESCALER_EN
      rd(5'h14, d);
      check("coll_hi_hold", d, 32'h5);
      rd(5'h10, d);
      step();
      rd(5'h14, d);
      check("coll_hi_inc", d, 32'h6);
      rd(5'h10, d);
      check("coll_lo_wrap", d, 32'h0);
`else
      rd(5'h14, d);
      check("coll_hi_inc", d, 32'h6);
      rd(5'h10, d);
      check("coll_lo_wrap", d, 32'h1);
`endif

      // edge set colliding with ack
      wr(5'h18, 32'h1);
      wr(5'h04, 32'h800);
      pulse_ext();
      step();
      step();
      check("sim_first", int_cause, C_MEI);
      pulse_ext();
      step();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      step();
      step();
      check("set_wins", interrupt, 1);
      rd(5'h18, d);
      check("set_wins_reg", d, 32'h3);
      wr(5'h18, 32'h3);
      step();
      check("w1c_clear", interrupt, 0);

      // reset in the middle of activity
      wr(5'h00, 32'h1);
      wr(5'h04, 32'h8);
      step();
      check("pre_reset_irq", interrupt, 1);
      do_reset();
      rd(5'h10, d);
      check("post_reset_mtime", d, 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         la = $urandom_range(0, 15);
         if (la == 15) a = 5'($urandom);
         else a = {3'(la), 2'b00};
         bus_addr = a;
         bus_we = ($urandom_range(0, 2) == 0);
         bus_re = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) bus_wdata = $urandom;
         else bus_wdata = $urandom_range(0, 600);
         if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
         int_ack = ($urandom_range(0, 3) == 0);
         step();
      end
      bus_we = 1'b0;
      bus_re = 1'b0;
      int_ack = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/intc_timer.md
# intc_timer

Machine-level interrupt source block for the pipelined RV32 core. Holds a 64-bit `mtime`/`mtimecmp` timer, a software-interrupt bit and a synchronised external interrupt line. It prioritises these sources and drives the single `interrupt` level and its cause code into the exception unit, directly upstream of it. The exception unit's `int_ack` retires edge-latched requests; software reads and writes all registers through a small MMIO port.

## Interface
- `PRESCALE_DIV`, default 4: `mtime` tick period in clocks; used only with the prescaler feature; legal range 2..65535.
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-low.
- `bus_addr` in 5: word-aligned MMIO offset (byte address [4:0]).
- `bus_we` in 1: write strobe, one cycle per write.
- `bus_re` in 1: read strobe, one cycle per read.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data; registered.
- `ext_irq` in 1: asynchronous external interrupt pin.
- `int_ack` in 1: one-cycle pulse from the exception unit when it takes an interrupt trap.
- `interrupt` out 1: interrupt request level, registered.
- `int_cause` out 32: mcause value of the highest-priority pending source, registered.

## Operation
- Register map (offset: function):
  - 0x00 `MSIP`: bit0 = software pending, R/W.
  - 0x04 `IE`: bit3 = MSIE, bit7 = MTIE, bit11 = MEIE, R/W; all other bits read 0.
  - 0x08 / 0x0C: `mtimecmp` low / high word.
  - 0x10 / 0x14: `mtime` low / high word.
  - 0x18 `EXTCTL`: bit0 = mode (0 level, 1 rising edge), bit1 = ext pending. Writing 1 to bit1 clears it.
  - Any other offset reads 0; writes to it are ignored.
- Reset values: `mtime` = 0, `mtimecmp` = all ones, `MSIP` = 0, `IE` = 0, `EXTCTL` = 0, `bus_rdata` = 0, `interrupt` = 0, `int_cause` = 0.
- `mtime` increments by 1 every enabled tick and wraps from 2^64-1 to 0.
- A bus write to an `mtime` word takes priority over the increment in the same cycle. Only the written word changes; the other word holds its value.
- Timer pending is unsigned 64-bit `mtime >= mtimecmp`. It is a level and clears only when software rewrites `mtimecmp`.
- `ext_irq` passes through a 2-flop synchroniser.
  - Level mode: external pending equals the synchronised value.
  - Edge mode: a synchronised 0→1 transition sets the sticky pending bit. `int_ack` clears it when the registered `int_cause` = 0x8000000B, and a W1C write to `EXTCTL` bit1 also clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- Software pending is `MSIP` bit0 and is cleared only by software.
- Each source is enabled by its `IE` bit. Priority is MEI > MSI > MTI, with causes 0x8000000B, 0x80000003 and 0x80000007.
- `interrupt` = OR of the enabled pending sources. `int_cause` holds the highest-priority cause, or 0 when none is pending.
- Global MIE gating is not done here; the exception unit applies it.

## Timing
- Bus write: a write seen at edge N is architecturally visible from cycle N+1.
- Bus read: data is sampled at edge N and appears on `bus_rdata` after edge N, held until the next read.
- `bus_re` and `bus_we` asserted together: the read returns the old value.
- `interrupt` and `int_cause` are registered, giving one cycle from a pending change to the output.
- External pin to `interrupt`: 3 clocks (2 synchroniser stages plus the output register). The edge latch does not add a cycle.
- After `int_ack` on an edge request, `interrupt` drops one cycle later, unless another source is still pending.
- `int_ack` is ignored when the registered cause is not 0x8000000B.
- Asserting `rst` mid-operation clears all state asynchronously. Registers are released synchronously on the first clock edge after deassertion.

## Configuration
- `INTC_PRESCALER_EN` defined:
  - A 16-bit prescaler counter counts 0..`PRESCALE_DIV`-1. `mtime` increments when it wraps to 0.
  - The prescaler resets to 0 and also resets to 0 on any `mtime` write.
- `INTC_PRESCALER_EN` undefined: `mtime` increments every clock, and `PRESCALE_DIV` is unused.

## Test plan
- Reset: drive `rst`=0, then release. Required: `mtime` reads 0, `mtimecmp` reads 0xFFFFFFFF in both words, `interrupt`=0, `int_cause`=0.
- Timer (no prescaler): write `mtimecmp`=10 (high word 0), `IE`=0x80. Required: `interrupt` rises with `int_cause`=0x80000007 the cycle after `mtime` reaches 10. It stays high until `mtimecmp` is written to 0xFFFFFFFF.
- Edge external: write `EXTCTL`=1 and `IE`=0x800, then give `ext_irq` a 1-cycle pulse. Required: `interrupt` is high 3 clocks later with cause 0x8000000B. `int_ack` drops it one cycle later.
- Priority: enable all three sources and make MSIP, timer and external pending at once. Required: cause sequence 0x8000000B, then 0x80000003 after ext is acked, then 0x80000007 after `MSIP` is cleared.
- Collision: write `mtime` low word = 0xFFFFFFFF in the same cycle as a tick. Required: it reads 0xFFFFFFFF. The next tick gives low 0 and high +1. With `INTC_PRESCALER_EN` and `PRESCALE_DIV`=4, ticks come every 4 clocks.
- Simultaneous set/ack: a synchronised edge arrives in the same cycle as `int_ack`. Required: pending remains 1 and `interrupt` stays high.
